sram_mem: RTL and testbench

- Single-port, synchronous, register-based static RAM with one shared address bus, a write-enable and a registered read-data output.
- Used as a small scratch/storage memory behind a simple en/we/addr bus interface (sram_if) driven by a verification environment or a bus master.
- Reset clears the whole array, so contents are deterministic after reset.

---
 rtl/sram_mem.sv | 49 ++++
 tb/tb_sram_mem.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sram_mem.sv
// rtl/sram_mem.sv - single-port synchronous register-based RAM with registered read data
module sram_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage array; every address value decodes to a real word, so no range guard is needed.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array update: reset clears every word and wins over any access in the same cycle.
    // The write path is only opened when en is high, so a floating we/addr/wdata while idle
    // can never reach the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: rdata only moves on a read and otherwise holds, rvalid marks the cycle it moved.
    // Reads sample the array before this edge's update, which is fine because a read and a
    // write never share a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (en && !we) begin
            rdata  <= mem[addr];
            rvalid <= 1'b1;
        end else begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_mem.sv
// tb/tb_sram_mem.sv - directed self-checking bench for sram_mem
module tb_sram_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;

    int errors = 0;
    int checks = 0;

    sram_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid)
    );

    always #5 clk = ~clk;

    // Apply one cycle of bus inputs, let the edge happen, then settle 1ns past it.
    task automatic step(input logic r, input logic e, input logic w,
                        input logic [3:0] a, input logic [7:0] d);
        rst = r; en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] raddr [3];
        raddr[0] = 4'h0; raddr[1] = 4'h7; raddr[2] = 4'hF;
        step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        checks++;
        if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 8'h00); end
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected %b", rvalid, 1'b0); end
        foreach (raddr[i]) begin
            step(1'b0, 1'b1, 1'b0, raddr[i], 8'h00);
            checks++;
            if (rdata !== 8'h00) begin errors++; $display("FAIL reset_read_%h: got %h expected %h", raddr[i], rdata, 8'h00); end
            checks++;
            if (rvalid !== 1'b1) begin errors++; $display("FAIL reset_read_rvalid_%h: got %b expected %b", raddr[i], rvalid, 1'b1); end
        end
    endtask

    task automatic test_write_readback();
        step(1'b0, 1'b1, 1'b1, 4'h3, 8'hA5);
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b0) begin errors++; $display("FAIL wr_hold_1: got %h/%b expected %h/%b", rdata, rvalid, 8'h00, 1'b0); end
        step(1'b0, 1'b1, 1'b1, 4'hC, 8'h5A);
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b0) begin errors++; $display("FAIL wr_hold_2: got %h/%b expected %h/%b", rdata, rvalid, 8'h00, 1'b0); end
        step(1'b0, 1'b1, 1'b0, 4'h3, 8'h00);
        checks++;
        if (rdata !== 8'hA5 || rvalid !== 1'b1) begin errors++; $display("FAIL b2b_read_3: got %h/%b expected %h/%b", rdata, rvalid, 8'hA5, 1'b1); end
        step(1'b0, 1'b1, 1'b0, 4'hC, 8'h00);
        checks++;
        if (rdata !== 8'h5A || rvalid !== 1'b1) begin errors++; $display("FAIL b2b_read_c: got %h/%b expected %h/%b", rdata, rvalid, 8'h5A, 1'b1); end
    endtask

    task automatic test_raw_overwrite();
        step(1'b0, 1'b1, 1'b1, 4'h6, 8'h11);
        checks++;
        if (rdata !== 8'h5A || rvalid !== 1'b0) begin errors++; $display("FAIL raw_hold_1: got %h/%b expected %h/%b", rdata, rvalid, 8'h5A, 1'b0); end
        step(1'b0, 1'b1, 1'b0, 4'h6, 8'h00);
        checks++;
        if (rdata !== 8'h11 || rvalid !== 1'b1) begin errors++; $display("FAIL raw_read_1: got %h/%b expected %h/%b", rdata, rvalid, 8'h11, 1'b1); end
        step(1'b0, 1'b1, 1'b1, 4'h6, 8'h22);
        checks++;
        if (rdata !== 8'h11 || rvalid !== 1'b0) begin errors++; $display("FAIL raw_hold_2: got %h/%b expected %h/%b", rdata, rvalid, 8'h11, 1'b0); end
        step(1'b0, 1'b1, 1'b0, 4'h6, 8'h00);
        checks++;
        if (rdata !== 8'h22 || rvalid !== 1'b1) begin errors++; $display("FAIL raw_read_2: got %h/%b expected %h/%b", rdata, rvalid, 8'h22, 1'b1); end
    endtask

    task automatic test_idle_hold();
        step(1'b0, 1'b1, 1'b0, 4'h3, 8'h00);
        checks++;
        if (rdata !== 8'hA5 || rvalid !== 1'b1) begin errors++; $display("FAIL idle_pre_read: got %h/%b expected %h/%b", rdata, rvalid, 8'hA5, 1'b1); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) step(1'b0, 1'b0, 1'bx, 4'hx, 8'hxx);
            else        step(1'b0, 1'b0, i[0], 4'(3 + i * 5), 8'(8'hC3 ^ i));
            checks++;
            if (rdata !== 8'hA5 || rvalid !== 1'b0) begin errors++; $display("FAIL idle_hold_%0d: got %h/%b expected %h/%b", i, rdata, rvalid, 8'hA5, 1'b0); end
        end
        step(1'b0, 1'b1, 1'b0, 4'h3, 8'h00);
        checks++;
        if (rdata !== 8'hA5 || rvalid !== 1'b1) begin errors++; $display("FAIL idle_post_read: got %h/%b expected %h/%b", rdata, rvalid, 8'hA5, 1'b1); end
    endtask

    task automatic test_boundary();
        logic [3:0] ra [4];
        logic [7:0] rx [4];
        ra[0] = 4'hF; rx[0] = 8'hFF;
        ra[1] = 4'h0; rx[1] = 8'h01;
        ra[2] = 4'hE; rx[2] = 8'h00;
        ra[3] = 4'h1; rx[3] = 8'h00;
        step(1'b0, 1'b1, 1'b1, 4'hF, 8'hFF);
        step(1'b0, 1'b1, 1'b1, 4'h0, 8'h01);
        foreach (ra[i]) begin
            step(1'b0, 1'b1, 1'b0, ra[i], 8'h00);
            checks++;
            if (rdata !== rx[i] || rvalid !== 1'b1) begin errors++; $display("FAIL boundary_%h: got %h/%b expected %h/%b", ra[i], rdata, rvalid, rx[i], 1'b1); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 4'(i), 8'(i ^ 8'h80));
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
            checks++;
            if (rdata !== 8'(i ^ 8'h80) || rvalid !== 1'b1) begin errors++; $display("FAIL fill_read_%0d: got %h/%b expected %h/%b", i, rdata, rvalid, 8'(i ^ 8'h80), 1'b1); end
        end
        step(1'b1, 1'b1, 1'b1, 4'h2, 8'h77);
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got %h/%b expected %h/%b", rdata, rvalid, 8'h00, 1'b0); end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
            checks++;
            if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++; $display("FAIL post_reset_read_%0d: got %h/%b expected %h/%b", i, rdata, rvalid, 8'h00, 1'b1); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        test_reset();
        test_write_readback();
        test_raw_overwrite();
        test_idle_hold();
        test_boundary();
        test_reset_mid();
        step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
